// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU opcode encoding, base opcodes and the decoded
// bundle handed from decode to execute.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_A    = 4'b0111,
    ALU_SHL  = 4'b1000,
    ALU_SHR  = 4'b1010,
    ALU_SHA  = 4'b1011,
    ALU_SLT  = 4'b1100,
    ALU_SLTU = 4'b1101,
    ALU_B    = 4'b1111
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e     alu_op;
    logic        sel_a;
    logic        sel_b;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        is_branch;
    logic        br_inv;
    logic        illegal;
  } dec_bundle_t;

  // funct3 -> ALU op for OP / OP-IMM; alt selects SUB / SHA.
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SHL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SHA : ALU_SHR;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_decode_comb.sv
// Pure combinational RV32I decoder: one instruction word in, one decoded
// bundle out. Illegal encodings produce a neutral ADD bundle with illegal=1.
module rv32i_decode_comb
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output dec_bundle_t bundle
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic        f7_ok_op;
  logic        is_shift_f3;

  assign opcode      = instr[6:0];
  assign f3          = instr[14:12];
  assign f7          = instr[31:25];
  assign imm_i       = {{20{instr[31]}}, instr[31:20]};
  assign imm_s       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u       = {instr[31:12], 12'b0};
  assign is_shift_f3 = (f3 == 3'b001) || (f3 == 3'b101);
  // The alternate funct7 is only meaningful for SUB and SRA/SRAI.
  assign f7_ok_op    = (f7 == F7_BASE) ||
                       ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));

  always_comb begin
    // NOTE: every field gets a default before the case, so no path through
    // this block can leave a signal unassigned and infer a latch.
    bundle        = '0;
    bundle.alu_op = ALU_ADD;

    case (opcode)
      OPC_OP: begin
        bundle.alu_op  = arith_op(f3, f7[5]);
        bundle.illegal = !f7_ok_op;
      end
      OPC_OP_IMM: begin
        bundle.sel_b = 1'b1;
        if (is_shift_f3) begin
          bundle.alu_op  = arith_op(f3, f7[5]);
          bundle.imm     = {27'b0, instr[24:20]};
          bundle.illegal = !f7_ok_op;
        end else begin
          bundle.alu_op = arith_op(f3, 1'b0);
          bundle.imm    = imm_i;
        end
      end
      OPC_LUI: begin
        bundle.alu_op = ALU_B;
        bundle.sel_b  = 1'b1;
        bundle.imm    = imm_u;
      end
      OPC_AUIPC: begin
        bundle.sel_a = 1'b1;
        bundle.sel_b = 1'b1;
        bundle.imm   = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        // Execute computes the link value PC+4; the jump target is elsewhere.
        bundle.sel_a   = 1'b1;
        bundle.sel_b   = 1'b1;
        bundle.imm     = 32'd4;
        bundle.illegal = (opcode == OPC_JALR) && (f3 != 3'b000);
      end
      OPC_LOAD: begin
        bundle.sel_b = 1'b1;
        bundle.imm   = imm_i;
      end
      OPC_STORE: begin
        bundle.sel_b = 1'b1;
        bundle.imm   = imm_s;
      end
      OPC_BRANCH: begin
        bundle.is_branch = 1'b1;
        bundle.imm       = imm_b;
        bundle.br_inv    = f3[0];
        case (f3[2:1])
          2'b00:   bundle.alu_op = ALU_SUB;
          2'b10:   bundle.alu_op = ALU_SLT;
          2'b11:   bundle.alu_op = ALU_SLTU;
          default: bundle.illegal = 1'b1;
        endcase
      end
      default: bundle.illegal = 1'b1;
    endcase

    if (bundle.illegal) begin
      bundle        = '0;
      bundle.alu_op = ALU_ADD;
      bundle.illegal = 1'b1;
    end

    bundle.rs1 = instr[19:15];
    bundle.rs2 = instr[24:20];
    bundle.rd  = instr[11:7];
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage: valid/ready handshake from fetch, one pipeline
// register of decoded bundle toward execute, with flush from branch resolution.
module alu_decode_stage
  import riscv_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_PC_OUT = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic            sel_a,
  output logic            sel_b,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] pc_out,
  output logic            is_branch,
  output logic            br_inv,
  output logic            illegal
);

  dec_bundle_t     dec;
  dec_bundle_t     bundle_d, bundle_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic            out_valid_d, out_valid_q;
  logic            accept;

  rv32i_decode_comb u_decode (
    .instr  (in_instr),
    .bundle (dec)
  );

  assign in_ready = !out_valid_q || out_ready;
  // Flush wins over an accept in the same cycle but leaves in_ready untouched.
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    pc_d        = pc_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
      pc_d        = in_pc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // pre-edge values regardless of process ordering.
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      pc_q        <= RESET_PC_OUT;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      pc_q        <= pc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op    = bundle_q.alu_op;
  assign sel_a     = bundle_q.sel_a;
  assign sel_b     = bundle_q.sel_b;
  assign imm       = bundle_q.imm;
  assign rs1       = bundle_q.rs1;
  assign rs2       = bundle_q.rs2;
  assign rd        = bundle_q.rd;
  assign pc_out    = pc_q;
  assign is_branch = bundle_q.is_branch;
  assign br_inv    = bundle_q.br_inv;
  assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: hand-decoded vectors, back-pressure,
// flush and asynchronous reset, checked with immediate assertions.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic        sel_a;
  logic        sel_b;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] pc_out;
  logic        is_branch;
  logic        br_inv;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  alu_decode_stage #(
    .XLEN         (32),
    .RESET_PC_OUT (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .imm       (imm),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .pc_out    (pc_out),
    .is_branch (is_branch),
    .br_inv    (br_inv),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_alu_op",    {28'b0, alu_op},    32'd0);
    check("rst_imm",       imm,                32'd0);
    check("rst_pc_out",    pc_out,             32'h0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    @(negedge clk);
    rst = 1'b0;

    // add x3,x1,x2
    send(32'h002081B3, 32'h0000_0100);
    check("add_valid",  {31'b0, out_valid}, 32'd1);
    check("add_op",     {28'b0, alu_op},    32'h0);
    check("add_sel_b",  {31'b0, sel_b},     32'd0);
    check("add_rs1",    {27'b0, rs1},       32'd1);
    check("add_rs2",    {27'b0, rs2},       32'd2);
    check("add_rd",     {27'b0, rd},        32'd3);
    check("add_pc",     pc_out,             32'h0000_0100);
    check("add_illegal",{31'b0, illegal},   32'd0);

    // sub x3,x1,x2
    send(32'h402081B3, 32'h0000_0104);
    check("sub_op", {28'b0, alu_op}, 32'h1);

    // srai x5,x6,3
    send(32'h40335293, 32'h0000_0108);
    check("srai_op",    {28'b0, alu_op}, 32'hB);
    check("srai_sel_b", {31'b0, sel_b},  32'd1);
    check("srai_imm",   imm,             32'd3);
    check("srai_rs1",   {27'b0, rs1},    32'd6);
    check("srai_rd",    {27'b0, rd},     32'd5);

    // lui x1,0x12345
    send(32'h123450B7, 32'h0000_010C);
    check("lui_op",    {28'b0, alu_op}, 32'hF);
    check("lui_sel_b", {31'b0, sel_b},  32'd1);
    check("lui_sel_a", {31'b0, sel_a},  32'd0);
    check("lui_imm",   imm,             32'h1234_5000);

    // bne x1,x2,+8
    send(32'h00209463, 32'h0000_0110);
    check("bne_op",     {28'b0, alu_op},    32'h1);
    check("bne_branch", {31'b0, is_branch}, 32'd1);
    check("bne_inv",    {31'b0, br_inv},    32'd1);
    check("bne_imm",    imm,                32'd8);
    check("bne_sel_b",  {31'b0, sel_b},     32'd0);

    // auipc x5,1
    send(32'h00001297, 32'h0000_0114);
    check("auipc_op",    {28'b0, alu_op}, 32'h0);
    check("auipc_sel_a", {31'b0, sel_a},  32'd1);
    check("auipc_imm",   imm,             32'h0000_1000);

    // jal x1,+8 : link value PC+4
    send(32'h008000EF, 32'h0000_0118);
    check("jal_sel_a", {31'b0, sel_a}, 32'd1);
    check("jal_sel_b", {31'b0, sel_b}, 32'd1);
    check("jal_imm",   imm,            32'd4);

    // sw x2,-4(x1)
    send(32'hFE20AE23, 32'h0000_011C);
    check("sw_op",  {28'b0, alu_op}, 32'h0);
    check("sw_imm", imm,             32'hFFFF_FFFC);
    check("sw_branch", {31'b0, is_branch}, 32'd0);

    // Back-pressure: sub waits while the store bundle is held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h402081B3;
    in_pc     = 32'h0000_0300;
    #1;
    check("bp_in_ready0", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_pc",    pc_out,             32'h0000_011C);
      check("bp_hold_imm",   imm,                32'hFFFF_FFFC);
      check("bp_in_ready",   {31'b0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("bp_new_pc", pc_out,          32'h0000_0300);
    check("bp_new_op", {28'b0, alu_op}, 32'h1);
    in_valid = 1'b0;
    tick();
    check("bp_drain_valid", {31'b0, out_valid}, 32'd0);
    check("bp_drain_pc",    pc_out,             32'h0000_0300);

    // Flush together with an accept: nothing is registered.
    flush = 1'b1;
    send(32'h002081B3, 32'h0000_0400);
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_pc",    pc_out,             32'h0000_0300);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();

    // Illegal encodings are still delivered.
    send(32'hFFFFFFFF, 32'h0000_0500);
    check("ill_valid",   {31'b0, out_valid}, 32'd1);
    check("ill_flag",    {31'b0, illegal},   32'd1);
    check("ill_op",      {28'b0, alu_op},    32'h0);
    check("ill_imm",     imm,                32'd0);
    send(32'h0000A063, 32'h0000_0504);
    check("brill_flag",   {31'b0, illegal},   32'd1);
    check("brill_branch", {31'b0, is_branch}, 32'd0);

    // Reset asserted mid-hold clears outputs without waiting for a clock.
    out_ready = 1'b0;
    send(32'h123450B7, 32'h0000_0600);
    tick();
    check("hold_before_rst", pc_out, 32'h0000_0504);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mid_op",    {28'b0, alu_op},    32'h0);
    check("rst_mid_imm",   imm,                32'd0);
    check("rst_mid_pc",    pc_out,             32'h0);
    check("rst_mid_rd",    {27'b0, rd},        32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
